// File: rtl/nic_pkg.sv
// rtl/nic_pkg.sv - shared constants for the NIC interface controller
package nic_pkg;

    localparam int NIC_DATA_WIDTH = 64;

    // Register select codes driven on addr by the processor
    localparam logic [1:0] NIC_IN_DATA  = 2'b00;
    localparam logic [1:0] NIC_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_OUT_DATA = 2'b10;
    localparam logic [1:0] NIC_OUT_STAT = 2'b11;

    // Status bit positions in [0:63] ordering (bit 0 is the MSB)
    localparam int NIC_NOT_EMPTY_BIT = 63;
    localparam int NIC_FULL_BIT      = 63;
    localparam int NIC_STICKY_BIT    = 62;

endpackage

// File: rtl/nic_fifo.sv
// rtl/nic_fifo.sv - strictly in-order channel FIFO with head look-ahead
module nic_fifo #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 64,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [0:DATA_WIDTH-1] pushData,
    input  logic                  pop,
    output logic [0:DATA_WIDTH-1] head,
    output logic                  full,
    output logic                  empty
);

    logic [0:DATA_WIDTH-1] mem [DEPTH];
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [PTR_W:0]        count;
    logic                  doPush;
    logic                  doPop;

    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign head   = empty ? '0 : mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/nic_if_ctrl.sv
// rtl/nic_if_ctrl.sv - processor register interface and router handshakes
module nic_if_ctrl
    import nic_pkg::*;
#(
    parameter int DATA_WIDTH = NIC_DATA_WIDTH,
    parameter int DEPTH      = 2,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:1]            addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicEnWr,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    logic                  rdEn;
    logic                  wrEn;
    logic                  inPop;
    logic                  inPush;
    logic                  inStatRd;
    logic                  outStatRd;
    logic                  outWr;
    logic                  outPop;
    logic                  inOvfSet;
    logic                  outDropSet;
    logic                  inOvf;
    logic                  outDrop;
    logic                  inFull;
    logic                  inEmpty;
    logic                  outFull;
    logic                  outEmpty;
    logic [0:DATA_WIDTH-1] inHead;
    logic [0:DATA_WIDTH-1] outHead;

    assign rdEn      = nicEn && !nicEnWr;
    assign wrEn      = nicEn && nicEnWr;
    assign inPop     = rdEn && (addr == NIC_IN_DATA);
    assign inStatRd  = rdEn && (addr == NIC_IN_STAT);
    assign outStatRd = rdEn && (addr == NIC_OUT_STAT);
    assign outWr     = wrEn && (addr == NIC_OUT_DATA);

    // Ready reflects current occupancy only; a same-cycle pop does not raise it
    assign net_ri    = reset && !inFull;
    assign inPush    = net_si && net_ri;
    assign inOvfSet  = net_si && !net_ri;

    // Fullness is sampled before this edge, so a same-cycle drain does not rescue a write
    assign outDropSet = outWr && outFull;

    // Injection only when the router phase matches the packet's VC bit
    assign net_so = !outEmpty && (net_polarity == outHead[0]);
    assign net_do = net_so ? outHead : '0;
    assign outPop = net_so && net_ro;

    nic_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_W      (PTR_W)
    ) inFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (inPush),
        .pushData (net_di),
        .pop      (inPop),
        .head     (inHead),
        .full     (inFull),
        .empty    (inEmpty)
    );

    nic_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_W      (PTR_W)
    ) outFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (outWr),
        .pushData (d_in),
        .pop      (outPop),
        .head     (outHead),
        .full     (outFull),
        .empty    (outEmpty)
    );

    // Sticky flags: a same-cycle set beats the clear-on-read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inOvf   <= 1'b0;
            outDrop <= 1'b0;
        end else begin
            if (inOvfSet)      inOvf <= 1'b1;
            else if (inStatRd) inOvf <= 1'b0;
            if (outDropSet)     outDrop <= 1'b1;
            else if (outStatRd) outDrop <= 1'b0;
        end
    end

    // Combinational register read mux, zero whenever no read is in progress
    always_comb begin
        d_out = '0;
        if (rdEn) begin
            case (addr)
                NIC_IN_DATA: d_out = inHead;
                NIC_IN_STAT: begin
                    d_out[NIC_NOT_EMPTY_BIT] = !inEmpty;
                    d_out[NIC_STICKY_BIT]    = inOvf;
                end
                NIC_OUT_STAT: begin
                    d_out[NIC_FULL_BIT]   = outFull;
                    d_out[NIC_STICKY_BIT] = outDrop;
                end
                default: d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nic_if_ctrl.sv
// tb/tb_nic_if_ctrl.sv - scoreboard bench for nic_if_ctrl against a queue model
module tb_nic_if_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [0:1]  addr = 2'b00;
    logic [0:63] d_in = '0;
    logic [0:63] d_out;
    logic        nicEn = 1'b0;
    logic        nicEnWr = 1'b0;
    logic        net_si = 1'b0;
    logic        net_ri;
    logic [0:63] net_di = '0;
    logic        net_so;
    logic        net_ro = 1'b0;
    logic [0:63] net_do;
    logic        net_polarity = 1'b0;

    nic_if_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicEnWr      (nicEnWr),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ri;
        logic        so;
        logic [0:63] ndo;
        logic [0:63] dout;
    } expRec_t;

    expRec_t     expQ[$];
    logic [0:63] mIn[$];
    logic [0:63] mOut[$];
    logic        mInOvf = 1'b0;
    logic        mOutDrop = 1'b0;
    int          checks = 0;
    int          fails = 0;
    bit          started = 0;
    bit          done = 0;

    task automatic check(input string name, input logic [0:63] act, input logic [0:63] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT outputs are compared against the queued expectation
    initial begin
        expRec_t r;
        forever begin
            @(negedge clk);
            if (started && !done) begin
                if (expQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL scoreboard_underflow: got 0 records expected 1 at %0t", $time);
                end else begin
                    r = expQ.pop_front();
                    check("net_ri", 64'(net_ri), 64'(r.ri));
                    check("net_so", 64'(net_so), 64'(r.so));
                    check("net_do", net_do, r.ndo);
                    check("d_out", d_out, r.dout);
                end
            end
        end
    end

    // One clock cycle: apply inputs, queue the expected outputs, advance the model
    task automatic step(input logic rs, input logic en, input logic wr, input logic [0:1] a,
                        input logic [0:63] din, input logic si, input logic [0:63] di,
                        input logic ro, input logic pol);
        expRec_t     r;
        logic [0:63] head;
        logic        inFullNow;
        logic        outFullNow;
        logic        rd;
        logic        wrOut;
        @(posedge clk);
        #1;
        reset = rs; nicEn = en; nicEnWr = wr; addr = a; d_in = din;
        net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
        if (!rs) begin
            mIn.delete();
            mOut.delete();
            mInOvf = 1'b0;
            mOutDrop = 1'b0;
        end
        inFullNow  = (mIn.size() == DEPTH);
        outFullNow = (mOut.size() == DEPTH);
        rd    = en && !wr;
        wrOut = en && wr && (a == 2'b10);
        head  = (mOut.size() > 0) ? mOut[0] : 64'h0;
        r.ri  = rs && !inFullNow;
        r.so  = (mOut.size() > 0) && (pol == head[0]);
        r.ndo = r.so ? head : 64'h0;
        r.dout = 64'h0;
        if (rd) begin
            case (a)
                2'b00: r.dout = (mIn.size() > 0) ? mIn[0] : 64'h0;
                2'b01: r.dout = {62'b0, mInOvf, mIn.size() > 0};
                2'b11: r.dout = {62'b0, mOutDrop, outFullNow};
                default: r.dout = 64'h0;
            endcase
        end
        expQ.push_back(r);
        started = 1;
        if (rs) begin
            if (si && !r.ri)        mInOvf = 1'b1;
            else if (rd && a == 2'b01) mInOvf = 1'b0;
            if (wrOut && outFullNow)   mOutDrop = 1'b1;
            else if (rd && a == 2'b11) mOutDrop = 1'b0;
            if (rd && a == 2'b00 && mIn.size() > 0) void'(mIn.pop_front());
            if (si && r.ri) mIn.push_back(di);
            if (r.so && ro) void'(mOut.pop_front());
            if (wrOut && !outFullNow) mOut.push_back(din);
        end
    endtask

    task automatic idle(input logic ro, input logic pol);
        step(1, 0, 0, 2'b00, 64'h0, 0, 64'h0, ro, pol);
    endtask

    task automatic cpuWrite(input logic [0:63] din, input logic ro, input logic pol);
        step(1, 1, 1, 2'b10, din, 0, 64'h0, ro, pol);
    endtask

    task automatic cpuRead(input logic [0:1] a, input logic si, input logic [0:63] di);
        step(1, 1, 0, a, 64'h0, si, di, 0, 0);
    endtask

    task automatic routerPush(input logic [0:63] di);
        step(1, 0, 0, 2'b00, 64'h0, 1, di, 0, 0);
    endtask

    initial begin
        // Reset held with the router pushing
        repeat (3) step(0, 0, 0, 2'b00, 64'h0, 1, 64'h55, 0, 0);
        idle(0, 0);
        cpuRead(2'b01, 0, 64'h0);
        cpuRead(2'b11, 0, 64'h0);

        // CPU send, then a transfer cycle that also reads out-status
        cpuWrite(64'h0000_0000_0000_00A5, 1, 0);
        step(1, 1, 0, 2'b11, 64'h0, 0, 64'h0, 1, 0);
        idle(1, 0);

        // Polarity gating
        cpuWrite(64'h8000_0000_0000_0001, 1, 0);
        idle(1, 0);
        idle(1, 0);
        idle(1, 1);
        idle(1, 1);

        // Output overflow and drain order
        cpuWrite(64'h1, 0, 0);
        cpuWrite(64'h2, 0, 0);
        cpuWrite(64'h3, 0, 0);
        cpuRead(2'b11, 0, 64'h0);
        cpuRead(2'b11, 0, 64'h0);
        repeat (3) idle(1, 0);

        // Input path with overflow sticky
        routerPush(64'h11);
        routerPush(64'h22);
        routerPush(64'h33);
        cpuRead(2'b01, 0, 64'h0);
        cpuRead(2'b00, 0, 64'h0);
        cpuRead(2'b00, 0, 64'h0);
        cpuRead(2'b01, 0, 64'h0);

        // Pop while full and router pushing: packet refused, accepted next cycle
        routerPush(64'h44);
        routerPush(64'h55);
        cpuRead(2'b00, 1, 64'h66);
        routerPush(64'h66);
        cpuRead(2'b00, 0, 64'h0);
        cpuRead(2'b00, 0, 64'h0);
        cpuRead(2'b00, 0, 64'h0);
        cpuRead(2'b01, 0, 64'h0);

        // Reset mid-transfer discards buffered packets
        routerPush(64'h77);
        cpuWrite(64'h88, 0, 0);
        step(0, 0, 0, 2'b00, 64'h0, 0, 64'h0, 1, 0);
        idle(1, 0);
        cpuRead(2'b00, 0, 64'h0);
        cpuRead(2'b01, 0, 64'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        rs;
            logic [0:1]  a;
            logic [0:63] din;
            logic [0:63] di;
            rs  = ($urandom_range(0, 199) != 0);
            a   = 2'($urandom_range(0, 3));
            din = {$urandom, $urandom};
            di  = {$urandom, $urandom};
            step(rs, rs && ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), a, din,
                 1'($urandom_range(0, 1)), di, ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));
        end

        idle(0, 0);
        @(negedge clk);
        #1;
        done = 1;
        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d records expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/nic_if_ctrl.md
Name: nic_if_ctrl

Overview:
- Network interface controller between the gold_processor NIC port (addr/d_in/d_out/nicEn/nicEnWr) and one router port of the NoC.
- Holds an input channel (router to CPU) and an output channel (CPU to router), each a small FIFO.
- Exposes four memory-mapped registers to the processor.
- Sequences valid/ready handshakes with the router, including even/odd virtual-channel polarity gating on injection.

Parameters:
- DATA_WIDTH, 64, packet/register width, bit 0 is MSB (codebase [0:N-1] ordering).
- DEPTH, 2, entries per channel FIFO; power of two, >= 2.
- PTR_W, 1, log2(DEPTH).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  [0:1]  register select: 00 in-data, 01 in-status, 10 out-data, 11 out-status.
- d_in  in  [0:63]  processor write data.
- d_out  out  [0:63]  processor read data.
- nicEn  in  1  register access enable.
- nicEnWr  in  1  write when 1, read when 0 (qualified by nicEn).
- net_si  in  1  router presents packet to NIC.
- net_ri  out  1  NIC input channel ready.
- net_di  in  [0:63]  packet from router.
- net_so  out  1  NIC presents packet to router.
- net_ro  in  1  router ready to accept.
- net_do  out  [0:63]  packet to router.
- net_polarity  in  1  router phase; injection allowed only when it equals packet bit 0 (VC bit).

Behaviour:
- Reset (reset=0, async):
  - All pointers and counts 0; sticky flags 0; FIFO contents don't-care.
  - net_so=0, net_ri=0 while reset is held; d_out=0.
  - Reset mid-transfer discards all buffered packets.
- d_out is combinational from addr when nicEn=1 && nicEnWr=0; otherwise 0.
  - addr 00: input FIFO head (0 if empty).
  - addr 01: bit63 = input not-empty, bit62 = input overflow sticky, other bits 0.
  - addr 11: bit63 = output full, bit62 = output-write-drop sticky, other bits 0.
  - addr 10: returns 0.
- Processor side effects, at the clock edge:
  - Read of 00 when input not empty: pops the input FIFO.
  - Read of 00 when input empty: no effect.
  - Read of 01 clears the input overflow sticky; read of 11 clears the write-drop sticky. Clear has priority over set only if set is not in the same cycle; a same-cycle set wins.
  - Write of 10 when output not full: pushes d_in. Write when full: dropped and sets write-drop sticky. Fullness is sampled at cycle start; a same-cycle drain does not rescue the write.
  - Writes to 00/01/11 are ignored.
- Router input channel:
  - net_ri = reset && !in_full, computed from current state only; a same-cycle CPU pop does not raise it.
  - Accept on net_si && net_ri; net_di is pushed at the edge.
  - net_si while net_ri=0 sets the input overflow sticky; the packet is not stored.
- Router output channel:
  - net_so = !out_empty && (net_polarity == head[0]).
  - net_do = head when net_so, else 0.
  - Transfer on net_so && net_ro; pop at the edge.
  - Latency: CPU write at edge N makes net_so visible after edge N (same-cycle combinational from new state). An empty-to-router path therefore costs 1 cycle.
- Simultaneous push and pop on one FIFO: both occur and the count is unchanged. Pointers wrap modulo DEPTH; count is PTR_W+1 bits.
- A full-to-empty transition and vice versa must not corrupt ordering; FIFO is strictly in order.

Decomposition:
- Package nic_pkg holds:
  - addr constants NIC_IN_DATA=2'b00, NIC_IN_STAT=2'b01, NIC_OUT_DATA=2'b10, NIC_OUT_STAT=2'b11;
  - status bit positions (NOT_EMPTY/FULL=63, STICKY=62);
  - DATA_WIDTH default.
- One sub-module nic_fifo (DEPTH, DATA_WIDTH; push/pop/head/full/empty, async active-low reset), instantiated twice.
- Top holds register decode, sticky flags and handshake logic.

Test Plan:
- Reset: hold reset=0 for 3 cycles with net_si=1 -> net_ri=0, net_so=0, d_out=0; release -> net_ri=1, status reads 0.
- CPU send: write 10 with d_in=64'h0000_0000_0000_00A5, net_polarity=0, net_ro=1 -> net_so=1 and net_do=...A5 the next cycle; out-status bit63 stays 0; net_so=0 after transfer.
- Polarity gating: write packet with bit0=1 while net_polarity=0 -> net_so=0; toggle polarity to 1 -> net_so=1 and transfer on net_ro.
- Output overflow: net_ro=0, write 3 packets (DEPTH=2) -> out-status reads 64'h3 (full + sticky); second status read -> 64'h1; drain 2 -> only first two packets emerge, in order.
- Input path: router pushes 64'h11 then 64'h22 -> net_ri=0; third net_si sets the sticky (in-status=64'h3); read 00 twice -> 64'h11 then 64'h22, then status 64'h0 after sticky clear.
- Simultaneous: input full, CPU pops while net_si=1 -> packet not accepted that cycle (net_ri was 0); accepted next cycle; no duplication or loss.
